// File: rtl/tt_um_nlp52_pair_triple_generator.sv
// rtl/tt_um_nlp52_pair_triple_generator.sv - paced 4-bit symbol generator with pair/triple injection
//
// Emits one symbol every MAX_COUNT cycles while run is high. Random symbols never
// repeat the previous one; on request a run of exactly two or three identical
// symbols is injected, with pair_mark/triple_mark flagging the closing symbol.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          design selected; when low the pacing counter, LFSR, FSM and last symbol hold
//   ui_in[0]     run (level)
//   ui_in[1]     inj_pair (rising edge)
//   ui_in[2]     inj_triple (rising edge, wins over a simultaneous pair edge)
//   ui_in[7:4]   inj_val
//   uo_out       {triple_mark, pair_mark, busy, sym_valid, sym[3:0]}
//   uio_in       unused
//   uio_out      emitted-symbol count mod 256
//   uio_oe       constant 8'hFF
module tt_um_nlp52_pair_triple_generator #(
  parameter int unsigned MAX_COUNT = 10000,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned TCW = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
  localparam logic [TCW-1:0] TC_LAST = TCW'(MAX_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EMIT} state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] tc_q, tc_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [3:0]     last_q, last_d;
  logic [3:0]     v_q, v_d;
  logic [1:0]     rem_q, rem_d;
  logic           triple_q, triple_d;
  logic [1:0]     req_s_q, req_s_d;
  logic [1:0]     req_p_q, req_p_d;
  logic [3:0]     sym_q, sym_d;
  logic           sym_valid_q, sym_valid_d;
  logic           busy_q, busy_d;
  logic           pair_mark_q, pair_mark_d;
  logic           triple_mark_q, triple_mark_d;
  logic [7:0]     cnt_q, cnt_d;

  logic       run;
  logic [3:0] inj_val;
  logic       tick;
  logic [1:0] rise;
  logic [7:0] lfsr_adv;
  logic [3:0] cand;
  logic       unused_ok;

  assign run       = ui_in[0];
  assign inj_val   = ui_in[7:4];
  assign unused_ok = &{1'b0, uio_in, ui_in[3]};

  always_comb begin
    tick     = ena && run && (tc_q == TC_LAST);
    rise     = req_s_q & ~req_p_q;
    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    lfsr_adv = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand     = lfsr_adv[3:0];

    state_d       = state_q;
    tc_d          = tc_q;
    lfsr_d        = lfsr_q;
    last_d        = last_q;
    v_d           = v_q;
    rem_d         = rem_q;
    triple_d      = triple_q;
    req_s_d       = req_s_q;
    req_p_d       = req_p_q;
    sym_d         = sym_q;
    sym_valid_d   = 1'b0;
    pair_mark_d   = 1'b0;
    triple_mark_d = 1'b0;
    cnt_d         = cnt_q;

    if (ena) begin
      req_s_d = ui_in[2:1];
      req_p_d = req_s_q;

      if (!run || tc_q == TC_LAST) tc_d = '0;
      else                         tc_d = tc_q + TCW'(1);

      if (tick) begin
        lfsr_d      = lfsr_adv;
        cnt_d       = cnt_q + 8'd1;
        sym_valid_d = 1'b1;
        if (state_q == S_IDLE) begin
          sym_d = (cand == last_q) ? cand + 4'd1 : cand;
        end else begin
          sym_d   = v_q;
          rem_d   = rem_q - 2'd1;
          state_d = S_EMIT;
          if (rem_q == 2'd1) begin
            state_d       = S_IDLE;
            pair_mark_d   = ~triple_q;
            triple_mark_d = triple_q;
          end
        end
        last_d = sym_d;
      end

      // A request accepted in the same cycle as a random emission is compared
      // against the symbol just emitted, so the injected run stays exact.
      if (state_q == S_IDLE && (|rise)) begin
        state_d  = S_ARMED;
        triple_d = rise[1];
        rem_d    = rise[1] ? 2'd3 : 2'd2;
        v_d      = (inj_val == last_d) ? inj_val + 4'd1 : inj_val;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tc_q          <= '0;
      lfsr_q        <= SEED;
      last_q        <= 4'd0;
      v_q           <= 4'd0;
      rem_q         <= 2'd0;
      triple_q      <= 1'b0;
      req_s_q       <= 2'd0;
      req_p_q       <= 2'd0;
      sym_q         <= 4'd0;
      sym_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      pair_mark_q   <= 1'b0;
      triple_mark_q <= 1'b0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      tc_q          <= tc_d;
      lfsr_q        <= lfsr_d;
      last_q        <= last_d;
      v_q           <= v_d;
      rem_q         <= rem_d;
      triple_q      <= triple_d;
      req_s_q       <= req_s_d;
      req_p_q       <= req_p_d;
      sym_q         <= sym_d;
      sym_valid_q   <= sym_valid_d;
      busy_q        <= busy_d;
      pair_mark_q   <= pair_mark_d;
      triple_mark_q <= triple_mark_d;
      cnt_q         <= cnt_d;
    end
  end

  assign uo_out  = {triple_mark_q, pair_mark_q, busy_q, sym_valid_q, sym_q};
  assign uio_out = cnt_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_nlp52_pair_triple_generator.sv
// tb/tb_tt_um_nlp52_pair_triple_generator.sv - self-checking bench for the pair/triple generator
module tb_tt_um_nlp52_pair_triple_generator;

  localparam int MC = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  tt_um_nlp52_pair_triple_generator #(.MAX_COUNT(MC), .SEED(SEED)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(ena), .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending injection is a queue of symbols still to be
  // emitted; random symbols come from the LFSR sequence with the no-repeat rule.
  int         m_tc;
  logic [7:0] m_lfsr, m_cnt;
  logic [3:0] m_sym, m_last, m_c, m_v;
  logic       m_valid, m_pair, m_tri, m_busy, m_is_tri, m_idle;
  logic [1:0] m_s1, m_s2, m_rise;
  logic [3:0] m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tc = 0; m_lfsr = SEED; m_cnt = 0; m_sym = 0; m_last = 0;
      m_valid = 0; m_pair = 0; m_tri = 0; m_busy = 0; m_is_tri = 0;
      m_s1 = 0; m_s2 = 0;
      m_q.delete();
    end else begin
      m_valid = 0; m_pair = 0; m_tri = 0;
      if (ena) begin
        m_rise = m_s1 & ~m_s2;
        m_idle = (m_q.size() == 0);
        if (ui_in[0] && m_tc == MC - 1) begin
          m_lfsr = (m_lfsr << 1) | {7'd0, ^(m_lfsr & 8'hB8)};
          m_cnt = m_cnt + 8'd1;
          m_valid = 1;
          if (m_q.size() > 0) begin
            m_sym = m_q.pop_front();
            if (m_q.size() == 0) begin
              if (m_is_tri) m_tri = 1; else m_pair = 1;
            end
          end else begin
            m_c = m_lfsr[3:0];
            m_sym = (m_c == m_last) ? m_c + 4'd1 : m_c;
          end
          m_last = m_sym;
        end
        if (m_idle && m_rise != 2'b00) begin
          m_is_tri = m_rise[1];
          m_v = (ui_in[7:4] == m_last) ? ui_in[7:4] + 4'd1 : ui_in[7:4];
          repeat (m_rise[1] ? 3 : 2) m_q.push_back(m_v);
        end
        m_tc = (ui_in[0] && m_tc != MC - 1) ? m_tc + 1 : 0;
        m_s2 = m_s1;
        m_s1 = ui_in[2:1];
      end
      m_busy = (m_q.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("uo_out", 32'(uo_out), 32'({m_tri, m_pair, m_busy, m_valid, m_sym}));
      chk("uio_out", 32'(uio_out), 32'(m_cnt));
      chk("uio_oe", 32'(uio_oe), 32'h0000_00FF);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Waits for the next sym_valid pulse; returns uo_out and the cycles waited.
  task automatic wait_sym(output logic [7:0] uo, output int n);
    n = 0;
    uo = 8'h00;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (uo_out[4]) begin
        uo = uo_out;
        return;
      end
    end
    chk("sym_valid timeout", 32'(n), 32'd0);
  endtask

  logic [7:0] uo;
  logic [3:0] v, prev_sym, lastv;
  logic [7:0] prev_cnt;
  int n;
  bit saw_wrap;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    #1;
    chk("reset uo_out", 32'(uo_out), 32'h0);
    chk("reset uio_out", 32'(uio_out), 32'h0);
    chk("reset uio_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;
    ui_in = 8'h01;
    chk_on = 1'b1;
    wait_sym(uo, n);
    chk("first latency", 32'(n), 32'd4);
    chk("first sym", 32'(uo[3:0]), 32'hA);
    chk("first count", 32'(uio_out), 32'd1);

    // Free run
    saw_wrap = 0;
    prev_sym = uo[3:0];
    prev_cnt = uio_out;
    for (int i = 0; i < 300; i++) begin
      wait_sym(uo, n);
      chk("free period", 32'(n), 32'd4);
      chk("free no repeat", 32'(uo[3:0] != prev_sym), 32'd1);
      chk("free no marks", 32'(uo[7:6]), 32'd0);
      chk("free count", 32'(uio_out), 32'((prev_cnt + 8'd1) & 8'hFF));
      if (prev_cnt == 8'hFF && uio_out == 8'h00) saw_wrap = 1;
      prev_sym = uo[3:0];
      prev_cnt = uio_out;
    end
    chk("count wrapped", 32'(saw_wrap), 32'd1);

    // Pair with inj_val 9, requested while paused
    ui_in = 8'h90;
    step(1);
    v = (m_last == 4'h9) ? 4'hA : 4'h9;
    ui_in = 8'h92;
    step(2);
    ui_in = 8'h90;
    step(1);
    chk("pair busy", 32'(uo_out[5]), 32'd1);
    ui_in = 8'h91;
    wait_sym(uo, n);
    chk("pair sym1", 32'(uo[3:0]), 32'(v));
    chk("pair mark1", 32'(uo[7:6]), 32'd0);
    wait_sym(uo, n);
    chk("pair sym2", 32'(uo[3:0]), 32'(v));
    chk("pair mark2", 32'(uo[7:6]), 32'b01);
    chk("pair busy end", 32'(uo[5]), 32'd0);
    wait_sym(uo, n);
    chk("pair after", 32'(uo[3:0] != v), 32'd1);

    // Triple with inj_val equal to last; a pair edge during busy is ignored
    ui_in = 8'h00;
    step(1);
    lastv = m_last;
    v = lastv + 4'd1;
    ui_in = {lastv, 4'b0100};
    step(2);
    ui_in = {lastv, 4'b0000};
    step(1);
    ui_in = {lastv, 4'b0001};
    wait_sym(uo, n);
    chk("triple sym1", 32'(uo[3:0]), 32'(v));
    chk("triple mark1", 32'(uo[7:6]), 32'd0);
    #1;
    ui_in = {lastv, 4'b0011};
    step(2);
    ui_in = {lastv, 4'b0001};
    wait_sym(uo, n);
    chk("triple sym2", 32'(uo[3:0]), 32'(v));
    chk("triple mark2", 32'(uo[7:6]), 32'd0);
    wait_sym(uo, n);
    chk("triple sym3", 32'(uo[3:0]), 32'(v));
    chk("triple mark3", 32'(uo[7:6]), 32'b10);
    for (int i = 0; i < 3; i++) begin
      wait_sym(uo, n);
      chk("after triple marks", 32'(uo[7:6]), 32'd0);
      if (i == 0) chk("after triple differs", 32'(uo[3:0] != v), 32'd1);
    end

    // Simultaneous edges: triple wins
    ui_in = 8'h30;
    step(1);
    v = (m_last == 4'h3) ? 4'h4 : 4'h3;
    ui_in = 8'h36;
    step(2);
    ui_in = 8'h31;
    for (int i = 0; i < 3; i++) begin
      wait_sym(uo, n);
      chk("simul sym", 32'(uo[3:0]), 32'(v));
      chk("simul pair mark", 32'(uo[6]), 32'd0);
      chk("simul triple mark", 32'(uo[7]), 32'(i == 2));
    end

    // Randomized: ena gaps, run pauses, injection edges, random values
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      ena = ($urandom_range(0, 9) != 0);
      ui_in[0] = ($urandom_range(0, 19) != 0);
      ui_in[3] = 1'($urandom);
      ui_in[7:4] = 4'($urandom);
      if ($urandom_range(0, 7) == 0) ui_in[2:1] = 2'($urandom);
      uio_in = 8'($urandom);
    end
    ena = 1'b1;
    ui_in = 8'h01;
    step(2);

    // Abort between the 1st and 2nd injected symbols
    ui_in = 8'hC0;
    step(1);
    ui_in = 8'hC4;
    step(2);
    ui_in = 8'hC1;
    wait_sym(uo, n);
    chk("abort first busy", 32'(uo[5]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort uo_out", 32'(uo_out), 32'h0);
    chk("abort uio_out", 32'(uio_out), 32'h0);
    chk("abort uio_oe", 32'(uio_oe), 32'hFF);
    ui_in = 8'h01;
    step(2);
    rst_n = 1'b1;
    wait_sym(uo, n);
    chk("abort restart latency", 32'(n), 32'd4);
    chk("abort restart sym", 32'(uo[3:0]), 32'hA);
    chk("abort restart marks", 32'(uo[7:6]), 32'd0);
    for (int i = 0; i < 7; i++) begin
      wait_sym(uo, n);
      chk("abort no marks", 32'(uo[7:6]), 32'd0);
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
